// File: rtl/c3lib_cksel_pkg.sv
// rtl/c3lib_cksel_pkg.sv - shared types and constants for the clock-mux select sequencer
//
// Purpose : FSM state encoding, field widths and a counter-load helper
//           shared by c3lib_ckmux4_sel_ctrl and c3lib_cksel_dncnt.
// Ports   : none (package)
package c3lib_cksel_pkg;

  localparam int CKSEL_SEL_W = 2;
  localparam int CKSEL_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    SETTLE = 2'd2
  } cksel_state_e;

  // A phase lasting N gated cycles loads N-1: the load edge itself is the first cycle.
  function automatic logic [CKSEL_CNT_W-1:0] cksel_ld(input int cyc);
    return CKSEL_CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/c3lib_cksel_dncnt.sv
// rtl/c3lib_cksel_dncnt.sv - loadable 8-bit down-counter with zero flag
//
// Purpose : shared interval counter for the GATE and SETTLE phases.
// Ports   : clk      in   reference clock
//           rst_n    in   asynchronous active-low reset
//           load     in   load load_val (has priority over dec)
//           load_val in 8 value to load
//           dec      in   decrement enable, holds at zero
//           cnt      out 8 current count
//           zero     out  count equals zero
module c3lib_cksel_dncnt
  import c3lib_cksel_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [CKSEL_CNT_W-1:0] load_val,
  input  logic                   dec,
  output logic [CKSEL_CNT_W-1:0] cnt,
  output logic                   zero
);

  logic [CKSEL_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign zero = (r_cnt == '0);

endmodule

// File: rtl/c3lib_ckmux4_sel_ctrl.sv
// rtl/c3lib_ckmux4_sel_ctrl.sv - glitch-free select sequencer for a 4:1 clock mux
//
// Purpose : accepts select-change requests, gates the downstream clock for
//           PRE_CYC cycles, switches {s1,s0}, waits POST_CYC cycles, then
//           re-enables the clock and pulses done.
// Ports   : clk      in   free-running reference clock
//           rst_n    in   asynchronous active-low reset
//           req_vld  in   request valid
//           req_sel  in 2 requested {s1,s0}
//           req_rdy  out  request can be accepted (IDLE)
//           s0, s1   out  registered mux selects
//           ck_en    out  registered downstream clock-gate enable
//           done     out  one-cycle completion pulse
//           sw_cnt   out 8 saturating completed-switch count (C3LIB_CKSEL_STAT_EN only)
// Option  : C3LIB_CKSEL_STAT_EN adds the sw_cnt port and counter.
module c3lib_ckmux4_sel_ctrl
  import c3lib_cksel_pkg::*;
#(
  parameter int                     PRE_CYC  = 4,
  parameter int                     POST_CYC = 8,
  parameter logic [CKSEL_SEL_W-1:0] RST_SEL  = 2'b00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_vld,
  input  logic [CKSEL_SEL_W-1:0] req_sel,
  output logic                   req_rdy,
  output logic                   s0,
  output logic                   s1,
  output logic                   ck_en,
  output logic                   done
`ifdef C3LIB_CKSEL_STAT_EN
  ,
  output logic [CKSEL_CNT_W-1:0] sw_cnt
`endif
);

  localparam logic [CKSEL_CNT_W-1:0] PRE_LD  = cksel_ld(PRE_CYC);
  localparam logic [CKSEL_CNT_W-1:0] POST_LD = cksel_ld(POST_CYC);

  cksel_state_e           r_state, w_state_nxt;
  logic [CKSEL_SEL_W-1:0] r_sel, w_sel_nxt;
  logic [CKSEL_SEL_W-1:0] r_pend, w_pend_nxt;
  logic                   r_ck_en, w_ck_en_nxt;
  logic                   r_done, w_done_nxt;
  logic                   w_ld, w_dec, w_zero;
  logic [CKSEL_CNT_W-1:0] w_ld_val;
  logic [CKSEL_CNT_W-1:0] w_cnt;

  c3lib_cksel_dncnt u_dncnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_ld),
    .load_val (w_ld_val),
    .dec      (w_dec),
    .cnt      (w_cnt),
    .zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= RST_SEL;
      r_pend  <= RST_SEL;
      r_ck_en <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_pend  <= w_pend_nxt;
      r_ck_en <= w_ck_en_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_pend_nxt  = r_pend;
    w_ck_en_nxt = r_ck_en;
    w_done_nxt  = 1'b0;
    w_ld        = 1'b0;
    w_ld_val    = '0;
    w_dec       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_vld) begin
          if (req_sel == r_sel) begin
            // Nothing to switch: acknowledge without gating the clock.
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = GATE;
            w_ck_en_nxt = 1'b0;
            w_pend_nxt  = req_sel;
            w_ld        = 1'b1;
            w_ld_val    = PRE_LD;
          end
        end
      end
      GATE: begin
        if (w_zero) begin
          // Clock is fully gated here, so the mux may switch safely.
          w_state_nxt = SETTLE;
          w_sel_nxt   = r_pend;
          w_ld        = 1'b1;
          w_ld_val    = POST_LD;
        end else begin
          w_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (w_zero) begin
          w_state_nxt = IDLE;
          w_ck_en_nxt = 1'b1;
          w_done_nxt  = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign req_rdy = (r_state == IDLE);
  assign s0      = r_sel[0];
  assign s1      = r_sel[1];
  assign ck_en   = r_ck_en;
  assign done    = r_done;

`ifdef C3LIB_CKSEL_STAT_EN
  logic [CKSEL_CNT_W-1:0] r_sw_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_cnt <= '0;
    end else if ((r_state == SETTLE) && w_zero && (r_sw_cnt != '1)) begin
      r_sw_cnt <= r_sw_cnt + 1'b1;
    end
  end

  assign sw_cnt = r_sw_cnt;
`else
  // Count value is only observed through the zero flag.
  logic w_cnt_unused;
  assign w_cnt_unused = ^w_cnt;
`endif

endmodule

// File: tb/tb_c3lib_ckmux4_sel_ctrl.sv
// tb/tb_c3lib_ckmux4_sel_ctrl.sv - self-checking bench for c3lib_ckmux4_sel_ctrl
module tb_c3lib_ckmux4_sel_ctrl;

  localparam int         P0 = 4;
  localparam int         Q0 = 8;
  localparam logic [1:0] R0 = 2'b00;
  localparam int         P1 = 1;
  localparam int         Q1 = 1;
  localparam logic [1:0] R1 = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld0, vld1;
  logic [1:0] sel0, sel1;
  logic       rdy0, rdy1, s00, s01, s10, s11, cke0, cke1, done0, done1;
  logic [7:0] cnt0, cnt1;

  always #5 clk = ~clk;

  c3lib_ckmux4_sel_ctrl #(.PRE_CYC(P0), .POST_CYC(Q0), .RST_SEL(R0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_vld(vld0), .req_sel(sel0), .req_rdy(rdy0),
    .s0(s00), .s1(s10), .ck_en(cke0), .done(done0)
`ifdef C3LIB_CKSEL_STAT_EN
    , .sw_cnt(cnt0)
`endif
  );

  c3lib_ckmux4_sel_ctrl #(.PRE_CYC(P1), .POST_CYC(Q1), .RST_SEL(R1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_vld(vld1), .req_sel(sel1), .req_rdy(rdy1),
    .s0(s01), .s1(s11), .ck_en(cke1), .done(done1)
`ifdef C3LIB_CKSEL_STAT_EN
    , .sw_cnt(cnt1)
`endif
  );

`ifndef C3LIB_CKSEL_STAT_EN
  assign cnt0 = 8'd0;
  assign cnt1 = 8'd0;
`endif

  int total = 0;
  int bad   = 0;
  int k     = 0;

  // Reference model: each accepted switch is a timeline of absolute edge indices.
  int         m_end [2];
  int         m_chg [2];
  int         m_cnt [2];
  logic [1:0] m_sel [2];
  logic [1:0] m_pend[2];
  bit         m_sw  [2];
  bit         m_done[2];
  bit         m_acc [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sel[d]  = (d == 0) ? R0 : R1;
      m_pend[d] = m_sel[d];
      m_end[d]  = k;
      m_chg[d]  = -1;
      m_sw[d]   = 1'b0;
      m_done[d] = 1'b0;
      m_acc[d]  = 1'b0;
      m_cnt[d]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic       v;
      logic [1:0] s;
      int         pre, post;
      bit         idle_before;
      v    = (d == 0) ? vld0 : vld1;
      s    = (d == 0) ? sel0 : sel1;
      pre  = (d == 0) ? P0 : P1;
      post = (d == 0) ? Q0 : Q1;
      idle_before = (k > m_end[d]);
      m_done[d] = 1'b0;
      m_acc[d]  = 1'b0;
      if (k == m_chg[d]) m_sel[d] = m_pend[d];
      if ((k == m_end[d]) && m_sw[d]) begin
        m_done[d] = 1'b1;
        m_sw[d]   = 1'b0;
        if (m_cnt[d] < 255) m_cnt[d]++;
      end
      if (idle_before && v) begin
        m_acc[d] = 1'b1;
        if (s == m_sel[d]) begin
          m_done[d] = 1'b1;
        end else begin
          m_pend[d] = s;
          m_chg[d]  = k + pre;
          m_end[d]  = k + pre + post;
          m_sw[d]   = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      string p;
      bit    en_exp;
      p      = (d == 0) ? "d0_" : "d1_";
      en_exp = (k >= m_end[d]);
      chk({p, "ck_en"}, (d == 0) ? cke0 : cke1, en_exp);
      chk({p, "req_rdy"}, (d == 0) ? rdy0 : rdy1, en_exp);
      chk({p, "done"}, (d == 0) ? done0 : done1, m_done[d]);
      chk({p, "sel"}, (d == 0) ? {s10, s00} : {s11, s01}, m_sel[d]);
`ifdef C3LIB_CKSEL_STAT_EN
      chk({p, "sw_cnt"}, (d == 0) ? cnt0 : cnt1, m_cnt[d]);
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    k++;
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_outputs();
  endtask

  // Raise a request and wait for acceptance; leaves req_vld high for the caller.
  task automatic request(input int d, input logic [1:0] s, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    if (d == 0) begin vld0 = 1'b1; sel0 = s; end
    else        begin vld1 = 1'b1; sel1 = s; end
    for (int i = 0; i < 100 && !got; i++) begin
      cycle();
      waited++;
      got = m_acc[d];
    end
    if (!got) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic drop(input int d);
    if (d == 0) vld0 = 1'b0;
    else        vld1 = 1'b0;
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    vld0  = 1'b0;
    vld1  = 1'b0;
    sel0  = 2'b00;
    sel1  = 2'b00;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // First switch to 10, then same-select, then held back-to-back 01 and 11.
    request(0, 2'b10, w); drop(0);
    repeat (P0 + Q0 + 2) cycle();
    request(0, 2'b10, w); drop(0);
    request(0, 2'b01, w);
    chk("same_sel_next_acc", w, 1);
    request(0, 2'b11, w); drop(0);
    chk("b2b_wait", w, P0 + Q0 + 1);
    repeat (P0 + Q0 + 2) cycle();
    chk("b2b_final_sel", {s10, s00}, 2'b11);

    // Minimum-interval DUT: held back-to-back switches.
    request(1, 2'b01, w);
    request(1, 2'b10, w); drop(1);
    chk("p1_b2b_wait", w, P1 + Q1 + 1);
    repeat (4) cycle();

    // Reset in the middle of SETTLE.
    request(0, 2'b00, w); drop(0);
    repeat (P0 + 2) cycle();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_sel", {s10, s00}, R0);
    chk("rst_ck_en", cke0, 1);
    chk("rst_done", done0, 0);
    chk("rst_rdy", rdy0, 1);
    chk("rst_sel_d1", {s11, s01}, R1);
    model_reset();
    cycle();
    rst_n = 1'b1;
    request(0, 2'b01, w); drop(0);
    chk("post_rst_acc", w, 1);
    repeat (P0 + Q0 + 1) cycle();

    // Randomized traffic on both instances.
    for (int n = 0; n < 1500; n++) begin
      if (!vld0 && $urandom_range(0, 3) == 0) begin vld0 = 1'b1; sel0 = 2'($urandom); end
      if (!vld1 && $urandom_range(0, 2) == 0) begin vld1 = 1'b1; sel1 = 2'($urandom); end
      cycle();
      if (m_acc[0]) begin
        if ($urandom_range(0, 1) == 0) vld0 = 1'b0;
        else sel0 = 2'($urandom);
      end
      if (m_acc[1]) begin
        if ($urandom_range(0, 1) == 0) vld1 = 1'b0;
        else sel1 = 2'($urandom);
      end
    end
    drop(0);
    drop(1);
    repeat (P0 + Q0 + 2) cycle();

`ifdef C3LIB_CKSEL_STAT_EN
    for (int i = 0; i < 260; i++) begin
      request(0, m_sel[0] ^ 2'b11, w); drop(0);
      repeat (P0 + Q0) cycle();
    end
    chk("sw_cnt_sat", cnt0, 255);
    request(0, m_sel[0], w); drop(0);
    repeat (2) cycle();
    chk("sw_cnt_same_sel", cnt0, 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
